// File: rtl/issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// issue_ctrl_pkg : shared types and helpers for the ID/EX issue hazard control.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package issue_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'd0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Register 0 is hardwired, so it can never create a dependency.
  function automatic logic src_hit(input logic [REG_IDX_W-1:0] idx,
                                   input logic                 rd,
                                   input logic [REG_IDX_W-1:0] dest);
    return rd & (idx == dest) & (dest != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_timer.sv
// ---------------------------------------------------------------------------
// md_busy_timer : counts down the cycles HI/LO stays unavailable after mult/div.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_busy_timer #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_busy
);

  localparam int            CW       = 4;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] r_count;

  // A new start always reloads, even if a previous operation is still pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_busy = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/issue_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// issue_hazard_ctrl : PC / IF/ID / ID/EX sequencing for the dual-issue core.
// Optional stall statistics counter enabled by ISSUE_STALL_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module issue_hazard_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int RW         = REG_IDX_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid0,
  input  logic          id_valid1,
  input  logic [RW-1:0] id_rs0,
  input  logic [RW-1:0] id_rt0,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rt1,
  input  logic          id_rs_rd0,
  input  logic          id_rt_rd0,
  input  logic          id_rs_rd1,
  input  logic          id_rt_rd1,
  input  logic [RW-1:0] id_dest0,
  input  logic          id_we0,
  input  logic          id_hilo0,
  input  logic          id_hilo1,
  input  logic          ex_load0,
  input  logic          ex_load1,
  input  logic [RW-1:0] ex_dest0,
  input  logic [RW-1:0] ex_dest1,
  input  logic          md_start,
  input  logic          branch_taken,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          ifid_flush,
  output logic          idex_bubble0,
  output logic          idex_bubble1,
  output logic          split_active,
  output logic [31:0]   stall_count
);

  state_e r_state;
  state_e w_nstate;
  logic   w_split, w_chk0, w_md_busy;
  logic   w_lu0, w_lu1, w_lu, w_md, w_pd;

  md_busy_timer #(.LATENCY(MD_LATENCY)) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .i_start (md_start),
    .o_busy  (w_md_busy)
  );

  // Slot0 already issued in the first half of a split, so it is not rechecked.
  assign w_split = (r_state == ST_SPLIT);
  assign w_chk0  = ~w_split & id_valid0;

  assign w_lu0 = w_chk0 &
      ((ex_load0 & (src_hit(id_rs0, id_rs_rd0, ex_dest0) | src_hit(id_rt0, id_rt_rd0, ex_dest0))) |
       (ex_load1 & (src_hit(id_rs0, id_rs_rd0, ex_dest1) | src_hit(id_rt0, id_rt_rd0, ex_dest1))));
  assign w_lu1 = id_valid1 &
      ((ex_load0 & (src_hit(id_rs1, id_rs_rd1, ex_dest0) | src_hit(id_rt1, id_rt_rd1, ex_dest0))) |
       (ex_load1 & (src_hit(id_rs1, id_rs_rd1, ex_dest1) | src_hit(id_rt1, id_rt_rd1, ex_dest1))));
  assign w_lu  = w_lu0 | w_lu1;
  assign w_md  = w_md_busy & ((w_chk0 & id_hilo0) | (id_valid1 & id_hilo1));
  assign w_pd  = ~w_split & id_valid0 & id_valid1 & id_we0 &
                 (src_hit(id_rs1, id_rs_rd1, id_dest0) | src_hit(id_rt1, id_rt_rd1, id_dest0));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble0 = 1'b0;
    idex_bubble1 = 1'b0;
    w_nstate     = ST_RUN;
    if (branch_taken) begin
      ifid_flush   = 1'b1;
      idex_bubble0 = 1'b1;
      idex_bubble1 = 1'b1;
    end else if (w_lu || w_md) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_bubble0 = 1'b1;
      idex_bubble1 = 1'b1;
      w_nstate     = r_state;
    end else if (w_pd) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_bubble1 = 1'b1;
      w_nstate     = ST_SPLIT;
    end else if (w_split) begin
      idex_bubble0 = 1'b1;
    end
    // Reset must quiesce the pipeline immediately, not at the next edge.
    if (!reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble0 = 1'b1;
      idex_bubble1 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nstate;
    end
  end

  assign split_active = w_split;

`ifdef ISSUE_STALL_STATS_EN
  logic        w_stall_cyc;
  logic [31:0] r_stall_count;

  assign w_stall_cyc = ~branch_taken & (w_lu | w_md | w_pd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_stall_cyc) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_issue_hazard_ctrl : directed scoreboard bench for issue_hazard_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_issue_hazard_ctrl;

  localparam int RW = 5;

  // {pc_en, ifid_en, ifid_flush, bubble0, bubble1, split_active}
  localparam logic [5:0] E_RUN    = 6'b110000;
  localparam logic [5:0] E_STALL  = 6'b000110;
  localparam logic [5:0] E_STALLS = 6'b000111;
  localparam logic [5:0] E_PD     = 6'b000010;
  localparam logic [5:0] E_SPLIT  = 6'b110101;
  localparam logic [5:0] E_BR     = 6'b111110;
  localparam logic [5:0] E_BRS    = 6'b111111;
  localparam logic [5:0] E_RST    = 6'b001110;

  typedef struct packed {
    logic [7:0]  tag;
    logic        ifmask;
    logic [5:0]  sig;
    logic [31:0] sc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          id_valid0, id_valid1;
  logic [RW-1:0] id_rs0, id_rt0, id_rs1, id_rt1;
  logic          id_rs_rd0, id_rt_rd0, id_rs_rd1, id_rt_rd1;
  logic [RW-1:0] id_dest0;
  logic          id_we0;
  logic          id_hilo0, id_hilo1;
  logic          ex_load0, ex_load1;
  logic [RW-1:0] ex_dest0, ex_dest1;
  logic          md_start, branch_taken;
  logic          pc_en, ifid_en, ifid_flush, idex_bubble0, idex_bubble1, split_active;
  logic [31:0]   stall_count;

  exp_t        q[$];
  exp_t        m_exp;
  logic [5:0]  m_act;
  int          errors   = 0;
  int          checks   = 0;
  int          sc_model = 0;
  logic [7:0]  tag_n    = 8'd0;

  issue_hazard_ctrl #(.MD_LATENCY(4), .RW(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid0    (id_valid0),
    .id_valid1    (id_valid1),
    .id_rs0       (id_rs0),
    .id_rt0       (id_rt0),
    .id_rs1       (id_rs1),
    .id_rt1       (id_rt1),
    .id_rs_rd0    (id_rs_rd0),
    .id_rt_rd0    (id_rt_rd0),
    .id_rs_rd1    (id_rs_rd1),
    .id_rt_rd1    (id_rt_rd1),
    .id_dest0     (id_dest0),
    .id_we0       (id_we0),
    .id_hilo0     (id_hilo0),
    .id_hilo1     (id_hilo1),
    .ex_load0     (ex_load0),
    .ex_load1     (ex_load1),
    .ex_dest0     (ex_dest0),
    .ex_dest1     (ex_dest1),
    .md_start     (md_start),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble0 (idex_bubble0),
    .idex_bubble1 (idex_bubble1),
    .split_active (split_active),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_sc();
`ifdef ISSUE_STALL_STATS_EN
    return 32'(sc_model);
`else
    return 32'd0;
`endif
  endfunction

  // Two valid, independent instructions; slot0 writes r10, which slot1 does not read.
  task automatic idle();
    id_valid0 = 1'b1; id_valid1 = 1'b1;
    id_rs0 = 5'd1; id_rt0 = 5'd2; id_rs1 = 5'd3; id_rt1 = 5'd4;
    id_rs_rd0 = 1'b1; id_rt_rd0 = 1'b1; id_rs_rd1 = 1'b1; id_rt_rd1 = 1'b1;
    id_dest0 = 5'd10; id_we0 = 1'b1;
    id_hilo0 = 1'b0; id_hilo1 = 1'b0;
    ex_load0 = 1'b0; ex_load1 = 1'b0; ex_dest0 = 5'd11; ex_dest1 = 5'd12;
    md_start = 1'b0; branch_taken = 1'b0;
  endtask

  // Queue the expected response for the current inputs, then advance one clock.
  task automatic step(input logic [5:0] sig, input bit mask, input bit stall);
    exp_t e;
    e.tag    = tag_n;
    e.ifmask = mask;
    e.sig    = sig;
    e.sc     = exp_sc();
    q.push_back(e);
    tag_n = tag_n + 8'd1;
    @(posedge clk); #1;
    if (stall) sc_model++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_exp = q.pop_front();
      m_act = {pc_en, ifid_en, ifid_flush, idex_bubble0, idex_bubble1, split_active};
      if (m_exp.ifmask) m_act[4] = m_exp.sig[4];
      checks++;
      if (m_act !== m_exp.sig || stall_count !== m_exp.sc) begin
        errors++;
        $display("FAIL step%0d: got pc/ifen/fl/b0/b1/sp=%b sc=%0d, want %b sc=%0d",
                 m_exp.tag, m_act, stall_count, m_exp.sig, m_exp.sc);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk); #1;
    step(E_RST, 0, 0);
    reset = 1'b1;
    step(E_RUN, 0, 0);

    // Load-use
    ex_load0 = 1'b1; ex_dest0 = 5'd8; id_rs1 = 5'd8;
    step(E_STALL, 0, 1);
    ex_load0 = 1'b0;
    step(E_RUN, 0, 0);
    ex_load1 = 1'b1; ex_dest1 = 5'd0; id_rs0 = 5'd0;
    step(E_RUN, 0, 0);
    idle(); ex_load0 = 1'b1; ex_dest0 = 5'd8; id_rs1 = 5'd8; id_rs_rd1 = 1'b0;
    step(E_RUN, 0, 0);
    id_rs_rd1 = 1'b1; id_valid1 = 1'b0;
    step(E_RUN, 0, 0);
    id_valid1 = 1'b1; id_rs1 = 5'd3; ex_load0 = 1'b0; ex_load1 = 1'b1; ex_dest1 = 5'd8; id_rt0 = 5'd8;
    step(E_STALL, 0, 1);

    // Pair dependency and split
    idle(); id_dest0 = 5'd5; id_rt1 = 5'd5;
    step(E_PD, 0, 1);
    step(E_SPLIT, 0, 0);
    idle();
    step(E_RUN, 0, 0);
    id_dest0 = 5'd0; id_rt1 = 5'd0;
    step(E_RUN, 0, 0);
    id_dest0 = 5'd5; id_rt1 = 5'd5; id_we0 = 1'b0;
    step(E_RUN, 0, 0);
    id_we0 = 1'b1;
    step(E_PD, 0, 1);
    ex_load0 = 1'b1; ex_dest0 = 5'd1;
    step(E_SPLIT, 0, 0);
    ex_load0 = 1'b0;
    step(E_PD, 0, 1);
    ex_load0 = 1'b1; ex_dest0 = 5'd5;
    step(E_STALLS, 0, 1);
    ex_load0 = 1'b0;
    step(E_SPLIT, 0, 0);
    idle();
    step(E_RUN, 0, 0);

    // HI/LO busy, then reload on the second stall cycle
    md_start = 1'b1;
    step(E_RUN, 0, 0);
    md_start = 1'b0; id_hilo0 = 1'b1;
    step(E_STALL, 0, 1);
    step(E_STALL, 0, 1);
    step(E_STALL, 0, 1);
    step(E_RUN, 0, 0);
    id_hilo0 = 1'b0; md_start = 1'b1;
    step(E_RUN, 0, 0);
    md_start = 1'b0; id_hilo1 = 1'b1;
    step(E_STALL, 0, 1);
    md_start = 1'b1;
    step(E_STALL, 0, 1);
    md_start = 1'b0;
    step(E_STALL, 0, 1);
    step(E_STALL, 0, 1);
    step(E_STALL, 0, 1);
    step(E_RUN, 0, 0);

    // Branch overrides split and load-use
    idle(); id_dest0 = 5'd5; id_rt1 = 5'd5;
    step(E_PD, 0, 1);
    branch_taken = 1'b1;
    step(E_BRS, 1, 0);
    idle();
    step(E_RUN, 0, 0);
    ex_load0 = 1'b1; ex_dest0 = 5'd8; id_rs1 = 5'd8; branch_taken = 1'b1;
    step(E_BR, 1, 0);
    idle();
    step(E_RUN, 0, 0);

    // Asynchronous reset mid-split and mid-busy
    id_dest0 = 5'd5; id_rt1 = 5'd5;
    step(E_PD, 0, 1);
    idle(); reset = 1'b0; sc_model = 0;
    step(E_RST, 0, 0);
    reset = 1'b1;
    step(E_RUN, 0, 0);
    md_start = 1'b1;
    step(E_RUN, 0, 0);
    md_start = 1'b0; id_hilo0 = 1'b1;
    step(E_STALL, 0, 1);
    reset = 1'b0; sc_model = 0;
    step(E_RST, 0, 0);
    reset = 1'b1;
    step(E_RUN, 0, 0);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never observed, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
Sequencing controller for the ID/EX pipeline registers of the dual-issue 8-stage core. Each cycle it inspects the two decoded slots in ID and the loads in EX, then drives the PC, IF/ID and ID/EX register enables and flushes. It resolves four cases in a fixed priority:
- branch redirects
- load-use hazards
- multiply/divide (HI/LO) busy stalls
- intra-pair dependencies, handled by splitting the pair over two cycles

Parameters:
MD_LATENCY, 4, cycles HI/LO is unavailable after a mult/div starts (legal range 2..15)
RW, 5, register-index width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
id_valid0  in  1  ID slot0 holds a real instruction
id_valid1  in  1  ID slot1 holds a real instruction
id_rs0, id_rt0  in  RW  slot0 source indices
id_rs1, id_rt1  in  RW  slot1 source indices
id_rs_rd0, id_rt_rd0, id_rs_rd1, id_rt_rd1  in  1  the matching source is actually read
id_dest0  in  RW  slot0 destination index
id_we0  in  1  slot0 writes id_dest0
id_hilo0, id_hilo1  in  1  slot reads HI/LO (mfhi/mflo)
ex_load0, ex_load1  in  1  EX slot is a load
ex_dest0, ex_dest1  in  RW  EX slot destination
md_start  in  1  one-cycle pulse: mult/div enters EX
branch_taken  in  1  EX resolved a redirect this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID register synchronous clear
idex_bubble0  out  1  ID/EX slot0 loads a NOP instead of ID slot0
idex_bubble1  out  1  ID/EX slot1 loads a NOP instead of ID slot1
split_active  out  1  FSM is in SPLIT state
stall_count  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- All outputs are combinational from the FSM state, the MD counter and the inputs. No extra latency: each decision applies at the next clk edge.
- Reset asserted (async, reset = 0):
  - FSM = RUN, MD counter = 0, stall_count = 0.
  - Outputs while in reset: pc_en = 0, ifid_en = 0, ifid_flush = 1, idex_bubble0 = 1, idex_bubble1 = 1, split_active = 0.
  - Reset asserted in mid-operation (SPLIT or MD busy) abandons that work immediately.
- Hazard definitions:
  - Source match: a source match against register 0 never counts.
  - Load-use (LU): any read source of a valid slot equals ex_destN where ex_loadN = 1 and ex_destN != 0. In SPLIT state, only slot1 sources are checked.
  - MD busy: MD counter != 0 and (id_hilo0 & id_valid0 | id_hilo1 & id_valid1). In SPLIT state, only slot1 is checked.
  - Pair dependency (PD): state RUN, both slots valid, id_we0 = 1, id_dest0 != 0, and id_dest0 equals a read source of slot1.
- FSM states: RUN, SPLIT.
- Priority per cycle:
  1. branch_taken: pc_en = 1, ifid_flush = 1, bubble0 = bubble1 = 1, next state = RUN.
  2. LU or MD busy: pc_en = 0, ifid_en = 0, bubble0 = bubble1 = 1, state holds.
  3. RUN with PD: pc_en = 0, ifid_en = 0, bubble0 = 0, bubble1 = 1, next state = SPLIT.
  4. SPLIT: pc_en = 1, ifid_en = 1, bubble0 = 1, bubble1 = 0, next state = RUN.
  5. RUN, no hazard: pc_en = 1, ifid_en = 1, bubbles = 0.
  - Whenever bubble0 = 0, an invalid slot still passes its valid bit through unchanged.
- MD counter:
  - md_start loads MD_LATENCY-1, including while already busy (reload).
  - Otherwise it decrements when nonzero and saturates at 0.
  - It is unaffected by branch_taken and by stalls.
- Simultaneous events: branch_taken overrides every stall and the SPLIT state. md_start in the same cycle as an MD stall still loads the counter.

Optional Feature:
ISSUE_STALL_STATS_EN
- Defined: stall_count increments (wrapping at 2^32) on every cycle in which case 2 applies, or case 3 applies, while reset is deasserted.
- Undefined: stall_count is tied to 32'd0 and no counter flops are generated.

Decomposition:
- Package issue_ctrl_pkg holds:
  - the FSM state enum (RUN, SPLIT)
  - the RW constant
  - the NOP encoding 32'd0
  - a function src_hit(idx, rd, dest) that returns rd & (idx == dest) & (dest != 0)
- One natural sub-module: md_busy_timer (load, decrement, busy flag), instantiated once.

Test Plan:
1. Release reset (reset 0 → 1) with both slots valid and no hazards → cycle 1: pc_en = 1, ifid_en = 1, bubbles 0/0, stall_count = 0.
2. ex_load0 = 1, ex_dest0 = 8; slot1 has id_rs1 = 8 with id_rs_rd1 = 1 → pc_en = 0, ifid_en = 0, bubbles 1/1. Clear ex_load0 next cycle → normal issue. With the macro, stall_count = 1.
3. id_dest0 = 5, id_we0 = 1; slot1 has id_rt1 = 5 with id_rt_rd1 = 1 → cycle A: bubbles 0/1, pc_en = 0, next state SPLIT. Cycle B: bubbles 1/0, pc_en = 1, split_active = 1. Cycle C: back in RUN. Repeat with id_dest0 = 0 → no split.
4. Pulse md_start with MD_LATENCY = 4, then present id_hilo0 = 1 → stalled for 3 cycles, issues on the 4th cycle. A second md_start pulse on stall cycle 2 restarts the count at 3.
5. Enter SPLIT state, then assert branch_taken in the SPLIT cycle → ifid_flush = 1, bubbles 1/1, pc_en = 1, next state RUN. A branch coincident with an LU condition gives the same response.
6. Drive reset = 0 asynchronously mid-SPLIT and during MD busy → outputs go to their reset values immediately. After release the FSM is in RUN and the MD counter is 0.
